// File: rtl/bpb_pkg.sv
// -----------------------------------------------------------------------------
// bpb_pkg
// Shared definitions for the branch prediction buffer, the branch resolution
// stage and the update queue between them.
//   BPB_ADDR_W   : default predictor line address width
//   BPB_OFFSET_W : default entry-within-line (bank select) width
//   bpb_update_t : one predictor update {addr, offset, taken}
// -----------------------------------------------------------------------------
package bpb_pkg;

    localparam int BPB_ADDR_W   = 2;
    localparam int BPB_OFFSET_W = 2;

    typedef struct packed {
        logic [BPB_ADDR_W-1:0]   addr;
        logic [BPB_OFFSET_W-1:0] offset;
        logic                    taken;
    } bpb_update_t;

endpackage

// File: rtl/bpb_sync_fifo.sv
// -----------------------------------------------------------------------------
// bpb_sync_fifo
// Generic synchronous FIFO of bpb_update_t entries.
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   push, push_data    : write push_data at the tail (ignored while full)
//   pop                : advance the head (ignored while empty)
//   pop_data           : current head entry (valid while !empty)
//   full, empty, count : status derived from the registered pointers
// -----------------------------------------------------------------------------
module bpb_sync_fifo
    import bpb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  bpb_update_t              push_data,
    input  logic                     pop,
    output bpb_update_t              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits match.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    bpb_update_t    mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: resetting the pointers discards every entry.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_update_queue.sv
// -----------------------------------------------------------------------------
// branch_update_queue
// Buffers resolved-branch outcomes and drains them one per cycle onto the
// branch prediction buffer update port; flags and counts mispredictions.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   res_valid/res_ready   : outcome handshake (res_ready = !full)
//   res_addr/res_offset   : predictor line and bank of the resolved branch
//   res_taken             : actual outcome
//   res_predicted         : prediction used for this branch
//   upd_block             : holds off draining while high
//   update                : one-cycle update strobe
//   branch_result, buffer_addr, buffer_offset : update payload (held when idle)
//   mispredict            : one-cycle pulse per accepted mispredicted branch
//   mispredict_count      : saturating mispredict count
//   occupancy             : entries currently queued
//   overflow              : sticky, an offer arrived while full
// Widths ADDR_W/OFFSET_W must match the bpb_pkg defaults used by bpb_update_t.
// -----------------------------------------------------------------------------
module branch_update_queue
    import bpb_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_W      = BPB_ADDR_W,
    parameter int OFFSET_W    = BPB_OFFSET_W,
    parameter int CNT_W       = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             res_valid,
    output logic                             res_ready,
    input  logic [ADDR_W-1:0]                res_addr,
    input  logic [OFFSET_W-1:0]              res_offset,
    input  logic                             res_taken,
    input  logic                             res_predicted,
    input  logic                             upd_block,
    output logic                             update,
    output logic                             branch_result,
    output logic [ADDR_W-1:0]                buffer_addr,
    output logic [OFFSET_W-1:0]              buffer_offset,
    output logic                             mispredict,
    output logic [CNT_W-1:0]                 mispredict_count,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy,
    output logic                             overflow
);

    bpb_update_t push_data;
    bpb_update_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        pop;
    logic        misp_accept;

    // Ready comes only from registered state, so a full queue refuses an
    // offer even in the cycle it also drains.
    assign res_ready   = !fifo_full;
    assign accept      = res_valid && !fifo_full;
    assign pop         = !fifo_empty && !upd_block;
    assign misp_accept = accept && (res_taken != res_predicted);

    assign push_data = '{addr: res_addr, offset: res_offset, taken: res_taken};

    bpb_sync_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Payload registers keep the last update when nothing is popped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            update        <= 1'b0;
            branch_result <= 1'b0;
            buffer_addr   <= '0;
            buffer_offset <= '0;
        end else begin
            update <= pop;
            if (pop) begin
                branch_result <= head.taken;
                buffer_addr   <= head.addr;
                buffer_offset <= head.offset;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mispredict       <= 1'b0;
            mispredict_count <= '0;
            overflow         <= 1'b0;
        end else begin
            mispredict <= misp_accept;
            if (misp_accept && (mispredict_count != {CNT_W{1'b1}})) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
            if (res_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_update_queue
// Self-checking bench for branch_update_queue: accepted outcomes are pushed to
// a scoreboard and compared in order against each update strobe.
// -----------------------------------------------------------------------------
module tb_branch_update_queue;
    import bpb_pkg::*;

    localparam int QD = 4;
    localparam int AW = 2;
    localparam int OW = 2;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [AW-1:0] res_addr = '0;
    logic [OW-1:0] res_offset = '0;
    logic          res_taken = 1'b0;
    logic          res_predicted = 1'b0;
    logic          upd_block = 1'b0;
    logic          update;
    logic          branch_result;
    logic [AW-1:0] buffer_addr;
    logic [OW-1:0] buffer_offset;
    logic          mispredict;
    logic [CW-1:0] mispredict_count;
    logic [2:0]    occupancy;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;
    int cycleCnt = 0;
    int updateCount = 0;
    int lastUpdateCycle = 0;
    int mispPulses = 0;
    int maxOcc = 0;

    bpb_update_t sb[$];

    branch_update_queue #(
        .QUEUE_DEPTH (QD),
        .ADDR_W      (AW),
        .OFFSET_W    (OW),
        .CNT_W       (CW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_addr         (res_addr),
        .res_offset       (res_offset),
        .res_taken        (res_taken),
        .res_predicted    (res_predicted),
        .upd_block        (upd_block),
        .update           (update),
        .branch_result    (branch_result),
        .buffer_addr      (buffer_addr),
        .buffer_offset    (buffer_offset),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count),
        .occupancy        (occupancy),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge; the offer is taken
    // at the next edge if the queue shows ready now.
    task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr,
                                 input logic [OW-1:0] off, input logic taken,
                                 input logic pred, input logic block,
                                 output logic accepted, output int driveCycle);
        @(posedge clock);
        #1;
        res_valid     = valid;
        res_addr      = addr;
        res_offset    = off;
        res_taken     = taken;
        res_predicted = pred;
        upd_block     = block;
        accepted      = valid && res_ready;
        driveCycle    = cycleCnt;
        if (accepted) sb.push_back('{addr: addr, offset: off, taken: taken});
    endtask

    task automatic idle(input logic block);
        logic acc;
        int   dc;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, block, acc, dc);
    endtask

    task automatic drainQueue(input int limit, input string tag);
        for (int i = 0; i < limit && sb.size() != 0; i++) idle(1'b0);
        checkOutput(tag, sb.size(), 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        res_valid = 1'b0;
        upd_block = 1'b0;
        #1;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Update monitor: every strobe must match the oldest outstanding outcome.
    always @(negedge clock) begin
        if (!reset) begin
            if (update) begin
                bpb_update_t exp;
                updateCount++;
                lastUpdateCycle = cycleCnt;
                if (sb.size() == 0) begin
                    checkOutput("update_unexpected", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("buffer_addr", buffer_addr, exp.addr);
                    checkOutput("buffer_offset", buffer_offset, exp.offset);
                    checkOutput("branch_result", branch_result, exp.taken);
                end
            end
            if (mispredict) mispPulses++;
            if (occupancy > maxOcc) maxOcc = occupancy;
        end
    end

    initial begin
        logic acc;
        int   dc;
        int   uc0;
        int   fc;
        int   p0;
        int   attempts;
        int   accCnt;

        #2;
        doReset();
        checkOutput("rst_update", update, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_ready", res_ready, 1);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_misp_count", mispredict_count, 0);
        checkOutput("rst_mispredict", mispredict, 0);
        checkOutput("rst_buffer_addr", buffer_addr, 0);
        checkOutput("rst_buffer_offset", buffer_offset, 0);
        checkOutput("rst_branch_result", branch_result, 0);

        // Single outcome: strobe exactly once, two edges after the offer edge.
        applyStimulus(1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0, acc, dc);
        checkOutput("t1_accept", acc, 1);
        uc0 = updateCount;
        repeat (4) idle(1'b0);
        checkOutput("t1_update_count", updateCount - uc0, 1);
        checkOutput("t1_latency", lastUpdateCycle - dc, 2);
        checkOutput("t1_hold_update", update, 0);
        checkOutput("t1_hold_addr", buffer_addr, 2);
        checkOutput("t1_hold_offset", buffer_offset, 1);
        checkOutput("t1_hold_result", branch_result, 1);

        // Fill while blocked, overflow on a fifth offer, then drain back-to-back.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(i), OW'(3 - i), i[0], i[0], 1'b1, acc, dc);
            checkOutput("t2_fill_accept", acc, 1);
        end
        idle(1'b1);
        checkOutput("t2_full_ready", res_ready, 0);
        checkOutput("t2_full_occupancy", occupancy, 4);
        checkOutput("t2_no_overflow_yet", overflow, 0);
        applyStimulus(1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, acc, dc);
        checkOutput("t2_fifth_rejected", acc, 0);
        idle(1'b1);
        fc = cycleCnt;
        checkOutput("t2_overflow", overflow, 1);
        checkOutput("t2_occupancy_held", occupancy, 4);
        uc0 = updateCount;
        drainQueue(12, "t2_drain_timeout");
        checkOutput("t2_update_count", updateCount - uc0, 4);
        checkOutput("t2_back_to_back", lastUpdateCycle - fc, 5);
        checkOutput("t2_ready_after", res_ready, 1);
        checkOutput("t2_occupancy_after", occupancy, 0);

        // Full queue with a held offer while draining resumes.
        maxOcc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(i), OW'(i), 1'b1, 1'b1, 1'b1, acc, dc);
        end
        acc = 1'b0;
        attempts = 0;
        while (!acc && attempts < 6) begin
            applyStimulus(1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, acc, dc);
            attempts++;
        end
        checkOutput("t3_attempts", attempts, 2);
        idle(1'b0);
        drainQueue(12, "t3_drain_timeout");
        checkOutput("t3_max_occupancy", maxOcc, 4);
        checkOutput("t3_overflow_sticky", overflow, 1);

        // Reset with entries queued and an update showing.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, AW'(i), OW'(i), 1'b1, 1'b0, 1'b1, acc, dc);
        end
        idle(1'b1);
        idle(1'b0);
        checkOutput("t5_misp_count_pre", mispredict_count, 4);
        @(posedge clock);
        #1;
        checkOutput("t5_update_pre", update, 1);
        checkOutput("t5_occupancy_pre", occupancy, 3);
        reset = 1'b1;
        #1;
        sb.delete();
        checkOutput("t5_update_rst", update, 0);
        checkOutput("t5_occupancy_rst", occupancy, 0);
        checkOutput("t5_overflow_rst", overflow, 0);
        checkOutput("t5_misp_count_rst", mispredict_count, 0);
        checkOutput("t5_ready_rst", res_ready, 1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        uc0 = updateCount;
        repeat (5) idle(1'b0);
        checkOutput("t5_no_stale_update", updateCount - uc0, 0);
        checkOutput("t5_occupancy_after", occupancy, 0);

        // 300 mispredicts: pulse per accept, counter saturates at 255.
        p0 = mispPulses;
        accCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, AW'(i), OW'(i >> 2), i[0], !i[0], 1'b0, acc, dc);
            if (acc) accCnt++;
        end
        idle(1'b0);
        idle(1'b0);
        checkOutput("t4_pulses_10", mispPulses - p0, 10);
        checkOutput("t4_count_10", mispredict_count, 10);
        for (int i = 10; i < 300; i++) begin
            applyStimulus(1'b1, AW'(i), OW'(i >> 2), i[0], !i[0], 1'b0, acc, dc);
            if (acc) accCnt++;
        end
        repeat (3) idle(1'b0);
        checkOutput("t4_accepted", accCnt, 300);
        checkOutput("t4_pulses_300", mispPulses - p0, 300);
        checkOutput("t4_count_sat", mispredict_count, 255);
        p0 = mispPulses;
        applyStimulus(1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, acc, dc);
        repeat (3) idle(1'b0);
        checkOutput("t4_correct_no_pulse", mispPulses - p0, 0);
        checkOutput("t4_count_held", mispredict_count, 255);
        drainQueue(12, "t4_drain_timeout");

        // Same addr/offset twice: two separate updates, taken then not-taken.
        uc0 = updateCount;
        applyStimulus(1'b1, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0, acc, dc);
        applyStimulus(1'b1, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, acc, dc);
        idle(1'b0);
        drainQueue(12, "t6_drain_timeout");
        checkOutput("t6_update_count", updateCount - uc0, 2);
        checkOutput("t6_last_result", branch_result, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
